// File: rtl/clint_timer.sv
// CLINT subset: free-running 64-bit mtime with prescaler, mtimecmp compare and msip,
// exposed through a single-beat request/ack register window.
module clint_timer #(
    parameter int PRESCALE   = 1,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    output logic                  o_ack,
    output logic [31:0]           o_rdata,
    output logic                  o_timer_interrupt,
    output logic                  o_software_interrupt
);

    localparam int CW = $clog2(PRESCALE) + 1;
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [CW-1:0] LAST_COUNT = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_count;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [WW-1:0] word;
    logic          wr;
    logic          wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;
    logic [31:0]   rd_value;
    logic          unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return result;
    endfunction

    assign word             = i_addr[ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^i_addr[1:0];
    assign tick             = (pre_count == LAST_COUNT);
    assign wr               = i_req && i_we;
    assign wr_msip          = wr && (word == WW'(0));
    assign wr_cmp_lo        = wr && (word == WW'(1));
    assign wr_cmp_hi        = wr && (word == WW'(2));
    assign wr_time_lo       = wr && (word == WW'(3));
    assign wr_time_hi       = wr && (word == WW'(4));

    always_comb begin
        rd_value = '0;
        if      (word == WW'(0)) rd_value = {31'd0, msip};
        else if (word == WW'(1)) rd_value = mtimecmp[31:0];
        else if (word == WW'(2)) rd_value = mtimecmp[63:32];
        else if (word == WW'(3)) rd_value = mtime[31:0];
        else if (word == WW'(4)) rd_value = mtime[63:32];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_count <= '0;
        end else begin
            pre_count <= tick ? '0 : pre_count + 1'b1;
        end
    end

    // A software write to either half of mtime suppresses that cycle's tick entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime <= '0;
        end else if (wr_time_lo) begin
            mtime <= {mtime[63:32], merge_bytes(mtime[31:0], i_wdata, i_wstrb)};
        end else if (wr_time_hi) begin
            mtime <= {merge_bytes(mtime[63:32], i_wdata, i_wstrb), mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], i_wdata, i_wstrb);
            if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wdata, i_wstrb);
            if (wr_msip && i_wstrb[0]) msip <= i_wdata[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack                <= 1'b0;
            o_rdata              <= '0;
            o_timer_interrupt    <= 1'b0;
            o_software_interrupt <= 1'b0;
        end else begin
            o_ack                <= i_req;
            o_rdata              <= (i_req && !i_we) ? rd_value : '0;
            o_timer_interrupt    <= (mtime >= mtimecmp);
            o_software_interrupt <= msip;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: directed register scenarios plus random bus traffic,
// checked against a cycle-level behavioural model of the timer registers.
module tb_clint_timer;

    localparam int PRESCALE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
    logic        timer_irq;
    logic        sw_irq;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    int unsigned m_cycles;
    logic        m_tick;
    logic        exp_ack;
    logic        exp_timer;
    logic        exp_sw;
    logic [31:0] expected_q[$];

    clint_timer #(.PRESCALE(PRESCALE), .ADDR_WIDTH(5)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_req                (req),
        .i_we                 (we),
        .i_addr               (addr),
        .i_wdata              (wdata),
        .i_wstrb              (wstrb),
        .o_ack                (ack),
        .o_rdata              (rdata),
        .o_timer_interrupt    (timer_irq),
        .o_software_interrupt (sw_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return {31'd0, m_msip};
            3'd1:    return m_cmp[31:0];
            3'd2:    return m_cmp[63:32];
            3'd3:    return m_mtime[31:0];
            3'd4:    return m_mtime[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // mtime advances whenever the number of cycles since reset completes a prescale period.
    assign m_tick = ((m_cycles % PRESCALE) == PRESCALE - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime   <= 64'd0;
            m_cmp     <= '1;
            m_msip    <= 1'b0;
            m_cycles  <= 0;
            exp_ack   <= 1'b0;
            exp_timer <= 1'b0;
            exp_sw    <= 1'b0;
            expected_q.delete();
        end else begin
            exp_ack   <= req;
            exp_timer <= (m_mtime >= m_cmp);
            exp_sw    <= m_msip;
            m_cycles  <= m_cycles + 1;
            if (req) expected_q.push_back(we ? 32'd0 : model_read(addr));
            if (req && we && addr[4:2] == 3'd3)
                m_mtime <= {m_mtime[63:32], model_merge(m_mtime[31:0], wdata, wstrb)};
            else if (req && we && addr[4:2] == 3'd4)
                m_mtime <= {model_merge(m_mtime[63:32], wdata, wstrb), m_mtime[31:0]};
            else if (m_tick)
                m_mtime <= m_mtime + 64'd1;
            if (req && we && addr[4:2] == 3'd1) m_cmp[31:0]  <= model_merge(m_cmp[31:0], wdata, wstrb);
            if (req && we && addr[4:2] == 3'd2) m_cmp[63:32] <= model_merge(m_cmp[63:32], wdata, wstrb);
            if (req && we && addr[4:2] == 3'd0 && wstrb[0]) m_msip <= wdata[0];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("ack", ack, exp_ack);
        checkOutput("timer_irq", timer_irq, exp_timer);
        checkOutput("sw_irq", sw_irq, exp_sw);
        if (ack) begin
            if (expected_q.size() == 0) checkOutput("queue_depth", expected_q.size(), 1);
            else checkOutput("rdata", rdata, expected_q.pop_front());
        end else begin
            checkOutput("rdata_idle", rdata, 0);
        end
    end

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
    endtask

    task automatic applyIdle(input int n);
        repeat (n) begin
            @(negedge clk);
            req   = 1'b0;
            we    = 1'b0;
            addr  = 5'd0;
            wdata = 32'd0;
            wstrb = 4'd0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 5'd0;
        wdata = 32'd0;
        wstrb = 4'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] free-running mtime");
        applyIdle(20);
        applyStimulus(1'b0, 5'h0C, 32'd0, 4'h0);
        applyStimulus(1'b0, 5'h10, 32'd0, 4'h0);
        applyIdle(2);

        $display("[TB] timer compare");
        applyStimulus(1'b1, 5'h04, 32'h30, 4'hF);
        applyStimulus(1'b1, 5'h08, 32'h0, 4'hF);
        applyIdle(30);
        applyStimulus(1'b1, 5'h08, 32'h1, 4'hF);
        applyIdle(3);

        $display("[TB] software interrupt");
        applyStimulus(1'b1, 5'h00, 32'h1, 4'hF);
        applyIdle(2);
        applyStimulus(1'b0, 5'h00, 32'd0, 4'h0);
        applyStimulus(1'b1, 5'h00, 32'h0, 4'hF);
        applyIdle(3);

        $display("[TB] mtime carry and partial write");
        applyStimulus(1'b1, 5'h0C, 32'hFFFF_FFFE, 4'hF);
        applyStimulus(1'b1, 5'h10, 32'h0, 4'hF);
        applyIdle(2);
        applyStimulus(1'b0, 5'h0C, 32'd0, 4'h0);
        applyStimulus(1'b0, 5'h10, 32'd0, 4'h0);
        applyStimulus(1'b1, 5'h0C, 32'hABCD_1234, 4'b0011);
        applyStimulus(1'b0, 5'h0C, 32'd0, 4'h0);
        applyIdle(2);

        $display("[TB] back-to-back and unmapped");
        applyStimulus(1'b0, 5'h0C, 32'd0, 4'h0);
        applyStimulus(1'b0, 5'h10, 32'd0, 4'h0);
        applyStimulus(1'b0, 5'h14, 32'd0, 4'h0);
        applyStimulus(1'b1, 5'h14, 32'hDEAD_BEEF, 4'hF);
        for (int a = 0; a < 6; a++) applyStimulus(1'b0, 5'(a * 4), 32'd0, 4'h0);
        applyIdle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
                          $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) applyIdle($urandom_range(1, 3));
        end
        applyIdle(2);

        $display("[TB] reset during read");
        applyStimulus(1'b1, 5'h04, 32'h0, 4'hF);
        applyStimulus(1'b1, 5'h08, 32'h0, 4'hF);
        applyIdle(3);
        applyStimulus(1'b0, 5'h0C, 32'd0, 4'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_timer_irq", timer_irq, 0);
        checkOutput("reset_rdata", rdata, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyIdle(2);
        applyStimulus(1'b0, 5'h04, 32'd0, 4'h0);
        applyStimulus(1'b0, 5'h08, 32'd0, 4'h0);
        applyIdle(3);

        checkOutput("queue_drain", expected_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
